counter_period_decoder: RTL and testbench
=========================================

# counter_period_decoder

Receive-side companion to the programmable terminal-count counter. Watches the counter's registered `tc` output and its enable `E`, measures the number of enabled cycles between terminal events, and recovers the programmed terminal value. Reports each measured value, declares lock after a run of identical intervals, and flags any break in the period. Sits next to the counter in the same clock domain as a self-check and period monitor.

## Interface
- `SIZE`, 4: width of the recovered terminal value; must equal the counter's `SIZE`.
- `LOCK_N`, 2: consecutive equal intervals required to assert `locked`; range 1..15.

- `clk`  in  1  rising-edge clock, shared with the counter.
- `R_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `E`  in  1  enable; same signal that drives the counter's `E`.
- `tc`  in  1  counter terminal-count output; registered, holds its value while `E`=0.
- `period`  out  SIZE  last recovered terminal value.
- `period_valid`  out  1  one-cycle pulse: `period` updated this cycle.
- `locked`  out  1  level: `LOCK_N` consecutive intervals agreed and none broken since.
- `err`  out  1  one-cycle pulse: overflow or mismatch while locked.

## Operation
- Event = `tc & E` sampled at a rising edge. Cycles with `E`=0 change no state, counter or output; pulses still clear.
- Interval counter `cnt` (SIZE bits) counts E-qualified non-event cycles since the last event. At an event, `cnt` equals the programmed terminal value (terminal value D gives D non-event cycles between events; D=0 gives back-to-back events, `cnt`=0).
- States:
  - SEARCH: reset state. `cnt` held at 0. Event: `cnt`<=0, go TRACK. No outputs.
  - TRACK: non-event: `cnt`<=`cnt`+1. Event: `period`<=`cnt`, `period_valid`=1, `cnt`<=0. If a reference exists and `cnt`==reference, `match`<=`match`+1, otherwise `match`<=0. Reference <=`cnt`. When `match`+1 reaches `LOCK_N`, go LOCKED and set `locked`. With `LOCK_N`=1, the first completed interval locks.
  - LOCKED: non-event: `cnt`++. Event with `cnt`==`period`: `period_valid`=1, stay. Event with `cnt`!=`period`: `err`=1, `locked`<=0, `period`<=`cnt`, `period_valid`=1, reference<=`cnt`, `match`<=0, go TRACK.
- Overflow: non-event E cycle with `cnt`==2^SIZE-1 in TRACK or LOCKED: `err`=1, `locked`<=0, clear reference and `match`, go SEARCH. `period` keeps its last value.
- `err` is asserted in TRACK only on overflow. Mismatches before lock are silent and restart the match run.
- Arithmetic: `cnt` and `period` are unsigned SIZE bits; no wrap is allowed, because overflow is detected before wrap. `match` saturates at `LOCK_N`.

## Timing
- Reset (`R_n`=0, asynchronous): state SEARCH, `cnt`=0, `period`=0, `period_valid`=0, `locked`=0, `err`=0, reference invalid, `match`=0. Takes effect immediately, including mid-interval; the first event after release only starts a measurement.
- All outputs are registered. For an event sampled at edge k, `period`/`period_valid`/`err` change at edge k and are visible for the cycle after. `locked` rises at the same edge as the `period_valid` that completes the run.
- Event and overflow can never coincide, because overflow requires a non-event cycle.
- `E` low for any number of cycles between events has no effect on the measured value.

## Structure
- Shared package `counter_pkg`: state encoding localparams (SEARCH, TRACK, LOCKED, 2-bit) and the `LOCK_N` default. The counter's `SIZE` default moves here so both ends share it.
- One natural sub-module, `interval_counter`: holds `cnt` with clear, enable, increment and an `at_max` flag. The FSM, reference register and match logic stay in the top.

## Test plan
- Counter driven with `data`=3, `E`=1 constantly, `LOCK_N`=2 -> `period_valid` every 4 cycles with `period`=3; `locked` rises with the second `period_valid`; `err` never asserted.
- `data`=0 -> event every E cycle; `period`=0 from the second event; `locked` after the third event.
- `data`=5, `E` toggling 1/0 pseudo-randomly -> `period`=5 every interval; no `err`; outputs frozen across `E`=0 stretches.
- Locked on `data`=3, then the counter's `data` changes to 6 mid-interval -> one mismatching `period` (value in 4..6, depends on switch point) with `err` pulse and `locked`=0; `locked` returns after two intervals of `period`=6.
- `SIZE`=4, `tc` forced to 0 after one event -> `err` pulse on the 16th non-event E cycle; state SEARCH; `period` unchanged.
- `R_n` pulsed low mid-interval while locked -> all outputs 0 asynchronously; after release, first event produces no `period_valid`; lock is reacquired per `LOCK_N`.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared widths, lock depth and FSM encoding for the counter and its period decoder
package counter_pkg;
  localparam int SIZE_DEFAULT   = 4;
  localparam int LOCK_N_DEFAULT = 2;

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] TRACK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
endpackage

// File: rtl/counter_period_decoder_if.sv
// rtl/counter_period_decoder_if.sv - counter-side inputs and decoder status outputs
interface counter_period_decoder_if
  import counter_pkg::*;
#(
  parameter int SIZE = SIZE_DEFAULT
);
  logic            E;
  logic            tc;
  logic [SIZE-1:0] period;
  logic            period_valid;
  logic            locked;
  logic            err;

  modport master (output E, tc, input period, period_valid, locked, err);
  modport slave  (input E, tc, output period, period_valid, locked, err);
endinterface

// File: rtl/interval_counter.sv
// rtl/interval_counter.sv - enabled-cycle interval counter with synchronous clear and saturation flag
module interval_counter
  import counter_pkg::*;
#(
  parameter int SIZE = SIZE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            inc,
  output logic [SIZE-1:0] cnt,
  output logic            at_max
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + SIZE'(1);
    end
  end

  assign at_max = &cnt;
endmodule

// File: rtl/counter_period_decoder.sv
// rtl/counter_period_decoder.sv - recovers the counter's terminal value from tc spacing and tracks lock
module counter_period_decoder
  import counter_pkg::*;
#(
  parameter int SIZE   = SIZE_DEFAULT,
  parameter int LOCK_N = LOCK_N_DEFAULT
) (
  input logic                     clk,
  input logic                     R_n,
  counter_period_decoder_if.slave bus
);
  logic [1:0]      state;
  logic [SIZE-1:0] cnt;
  logic            at_max;
  logic [SIZE-1:0] ref_val;
  logic            ref_valid;
  logic [3:0]      match;
  logic [3:0]      match_next;
  logic [4:0]      run_len;
  logic            lock_hit;
  logic [SIZE-1:0] period_q;
  logic            period_valid_q;
  logic            locked_q;
  logic            err_q;
  logic            ev;
  logic            idle_step;
  logic            active;
  logic            overflow;

  assign ev        = bus.E & bus.tc;
  assign idle_step = bus.E & ~bus.tc;
  assign active    = (state == TRACK) || (state == LOCKED);
  assign overflow  = idle_step & active & at_max;

  interval_counter #(.SIZE(SIZE)) u_cnt (
    .clk    (clk),
    .rst_n  (R_n),
    .clr    ((state == SEARCH) | ev | overflow),
    .inc    (idle_step & active & ~at_max),
    .cnt    (cnt),
    .at_max (at_max)
  );

  // run_len is the number of consecutive agreeing intervals including this one
  always_comb begin
    match_next = 4'd0;
    if (ref_valid && (cnt == ref_val)) begin
      match_next = (match >= 4'(LOCK_N)) ? match : match + 4'd1;
    end
    run_len  = {1'b0, match_next} + 5'd1;
    lock_hit = (run_len >= 5'(LOCK_N));
  end

  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      state          <= SEARCH;
      ref_val        <= '0;
      ref_valid      <= 1'b0;
      match          <= 4'd0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      period_valid_q <= 1'b0;
      err_q          <= 1'b0;
      if (overflow) begin
        err_q     <= 1'b1;
        locked_q  <= 1'b0;
        ref_valid <= 1'b0;
        match     <= 4'd0;
        state     <= SEARCH;
      end else if (ev) begin
        case (state)
          SEARCH: state <= TRACK;
          TRACK: begin
            period_q       <= cnt;
            period_valid_q <= 1'b1;
            match          <= match_next;
            ref_val        <= cnt;
            ref_valid      <= 1'b1;
            if (lock_hit) begin
              state    <= LOCKED;
              locked_q <= 1'b1;
            end
          end
          LOCKED: begin
            period_valid_q <= 1'b1;
            if (cnt != period_q) begin
              err_q    <= 1'b1;
              locked_q <= 1'b0;
              period_q <= cnt;
              ref_val  <= cnt;
              match    <= 4'd0;
              state    <= TRACK;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = period_valid_q;
  assign bus.locked       = locked_q;
  assign bus.err          = err_q;
endmodule

// File: tb/tb_counter_period_decoder.sv
// tb/tb_counter_period_decoder.sv - scoreboard bench driving a modelled terminal-count counter
module tb_counter_period_decoder;
  import counter_pkg::*;

  localparam int SIZE   = 4;
  localparam int LOCK_N = 2;
  localparam int MAXC   = (1 << SIZE) - 1;

  logic clk = 1'b0;
  logic R_n = 1'b0;
  always #5 clk = ~clk;

  counter_period_decoder_if #(.SIZE(SIZE)) bus ();

  counter_period_decoder #(.SIZE(SIZE), .LOCK_N(LOCK_N)) dut (
    .clk (clk),
    .R_n (R_n),
    .bus (bus)
  );

  typedef struct {
    int due;
    int period;
    bit pv;
    bit err;
    bit locked;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // counter being observed: counts enabled cycles, tc high when count reaches data
  int data   = 3;
  int c      = 0;
  bit force0 = 1'b0;

  // reference: intervals, run of agreeing intervals, lock flag
  bit m_started, m_ref_known, m_locked;
  int m_gap, m_ref, m_run, m_period;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_started = 0; m_ref_known = 0; m_locked = 0;
    m_gap = 0; m_ref = 0; m_run = 0; m_period = 0;
  endfunction

  function automatic void expect_out(int p, bit pv, bit e, bit l);
    sb.push_back('{due: cyc + 1, period: p, pv: pv, err: e, locked: l});
  endfunction

  function automatic void model_cycle(bit e, bit t);
    int interval;
    if (!e) return;
    if (t) begin
      if (!m_started) begin
        m_started = 1;
        m_gap     = 0;
      end else begin
        interval = m_gap;
        m_gap    = 0;
        if (m_locked) begin
          if (interval == m_period) begin
            expect_out(m_period, 1, 0, 1);
          end else begin
            m_locked = 0; m_period = interval; m_ref = interval;
            m_ref_known = 1; m_run = 1;
            expect_out(interval, 1, 1, 0);
          end
        end else begin
          if (m_ref_known && interval == m_ref) m_run = (m_run + 1 > LOCK_N) ? LOCK_N : m_run + 1;
          else m_run = 1;
          m_ref = interval; m_ref_known = 1; m_period = interval;
          if (m_run >= LOCK_N) m_locked = 1;
          expect_out(interval, 1, 0, m_locked);
        end
      end
    end else if (m_started) begin
      if (m_gap == MAXC) begin
        expect_out(m_period, 0, 1, 0);
        m_started = 0; m_ref_known = 0; m_run = 0; m_locked = 0; m_gap = 0;
      end else begin
        m_gap++;
      end
    end
  endfunction

  task automatic step(input bit e);
    @(negedge clk);
    bus.E  = e;
    bus.tc = force0 ? 1'b0 : (c == data);
    model_cycle(e, bus.tc);
    if (e) begin
      if (bus.tc) c = 0;
      else c++;
    end
  endtask

  task automatic chk_level(input string name);
    step(1'b0);
    chk({name, " locked"}, 32'(bus.locked), 32'(m_locked));
    chk({name, " period"}, 32'(bus.period), 32'(m_period));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    bus.E = 1'b0;
    R_n   = 1'b0;
    #1;
    chk("reset period", 32'(bus.period), 0);
    chk("reset period_valid", 32'(bus.period_valid), 0);
    chk("reset locked", 32'(bus.locked), 0);
    chk("reset err", 32'(bus.err), 0);
    chk("reset pending", 32'(sb.size()), 0);
    sb.delete();
    model_reset();
    @(negedge clk);
    #2;
    R_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("period_valid", 32'(bus.period_valid), 32'(e.pv));
        chk("err", 32'(bus.err), 32'(e.err));
        chk("period", 32'(bus.period), 32'(e.period));
        chk("locked", 32'(bus.locked), 32'(e.locked));
      end else if (bus.period_valid || bus.err) begin
        chk("spurious pulse", 32'({bus.period_valid, bus.err}), 0);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bus.E  = 1'b0;
    bus.tc = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("por period", 32'(bus.period), 0);
    chk("por locked", 32'(bus.locked), 0);
    chk("por period_valid", 32'(bus.period_valid), 0);
    chk("por err", 32'(bus.err), 0);
    #2 R_n = 1'b1;

    data = 3; c = 0;
    repeat (40) step(1'b1);
    chk_level("data3");

    do_reset();
    data = 0; c = 0;
    repeat (20) step(1'b1);
    chk_level("data0");

    data = 5; c = 0;
    repeat (200) step(1'($urandom_range(0, 1)));
    chk_level("data5 gated");

    data = 3;
    repeat (40) step(1'b1);
    while (c != 1) step(1'b1);
    data = 6;
    repeat (60) step(1'b1);
    chk_level("switch to 6");

    force0 = 1'b1;
    repeat (25) step(1'b1);
    chk_level("overflow");
    force0 = 1'b0; c = 0;
    repeat (40) step(1'b1);
    chk_level("relock after overflow");

    while (c != 3) step(1'b1);
    do_reset();
    repeat (50) step(1'b1);
    chk_level("relock after reset");

    repeat (600) begin
      step(1'($urandom_range(0, 3) != 0));
      if (bus.E && bus.tc && $urandom_range(0, 7) == 0) data = $urandom_range(0, 7);
    end
    chk_level("random");

    repeat (3) step(1'b0);
    chk("scoreboard drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
